// File: rtl/retire_split.sv
// retire_split: retire/writeback stage with split-and-merge misaligned loads.
// Optional instret counter is built in when RETIRE_INSTRET_EN is defined.

package retire_split_pkg;
   typedef enum logic [3:0] {
      NOP, ADD, LB, LBU, LH, LHU, LW, SW
   } iType_e;
endpackage

module retire_split
   import retire_split_pkg::*;
#(
   parameter int MISALIGNED = 1,
   parameter int OUT_REG    = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        valid_i,
   input  logic        flush_i,
   input  logic        write_enable_i,
   input  logic [4:0]  rd_i,
   input  iType_e      instruction_operation_i,
   input  logic [31:0] result_i,
   input  logic [31:0] mem_data_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        stall_o,
   output logic        misaligned_o,
`ifdef RETIRE_INSTRET_EN
   output logic [63:0] instret_o,
   output logic        instret_inc_o,
`endif
   output logic        regbank_write_enable_o,
   output logic [4:0]  regbank_addr_o,
   output logic [31:0] regbank_data_o
);

   localparam logic MIS_EN = (MISALIGNED != 0);
   localparam logic OREG   = (OUT_REG != 0);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] first_q;
   logic [31:0] addr_q;
   logic [1:0]  off_q;
   iType_e      op_q;
   logic [4:0]  rd_q;
   logic        we_q;

   logic        wb_we_q, wb_we_d;
   logic [4:0]  wb_addr_q, wb_addr_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        wb_split_q, wb_split_d;

   logic        is_load;
   logic [2:0]  sz;
   logic [1:0]  off;
   logic        mis;
   logic        idle, hold, accept, start;
   logic        al_we;
   logic [31:0] al_data;
   logic [4:0]  sh_q;
   logic [31:0] merge_w;
   logic [31:0] merge_data;
   logic        merge;

   function automatic logic [31:0] ext(input iType_e op, input logic [31:0] w);
      case (op)
         LB:      ext = {{24{w[7]}}, w[7:0]};
         LBU:     ext = {24'h0, w[7:0]};
         LH:      ext = {{16{w[15]}}, w[15:0]};
         LHU:     ext = {16'h0, w[15:0]};
         default: ext = w;
      endcase
   endfunction

   // access size decode for the incoming operation
   always_comb begin
      is_load = 1'b1;
      sz      = 3'd4;
      case (instruction_operation_i)
         LB, LBU: sz = 3'd1;
         LH, LHU: sz = 3'd2;
         LW:      sz = 3'd4;
         default: is_load = 1'b0;
      endcase
   end

   assign off    = result_i[1:0];
   assign mis    = is_load & (({1'b0, off} + sz) > 3'd4);
   assign idle   = (state_q == S_IDLE);
   // OUT_REG=0 presents the registered split write on the shared port,
   // so upstream is held for that one cycle to avoid a collision
   assign hold   = ~OREG & wb_split_q;
   assign accept = valid_i & idle & ~hold;
   assign start  = accept & mis & ~flush_i & MIS_EN;

   assign misaligned_o = accept & mis & ~flush_i & ~MIS_EN;

   assign al_we   = accept & ~flush_i & ~mis & write_enable_i & (rd_i != 5'd0);
   assign al_data = is_load ? ext(instruction_operation_i,
                                  mem_data_i >> {off, 3'b000})
                            : result_i;

   assign sh_q       = {off_q, 3'b000};
   assign merge_w    = (first_q >> sh_q) |
                       (mem_rdata_i << (6'd32 - {1'b0, sh_q}));
   assign merge_data = ext(op_q, merge_w);

   // split-load sequencing: request, wait, drain after flush
   always_comb begin
      state_d = state_q;
      merge   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_REQ;
         end
         S_REQ: begin
            if (flush_i) begin
               state_d = (mem_gnt_i & ~mem_rvalid_i) ? S_DRAIN : S_IDLE;
            end else if (mem_gnt_i) begin
               if (mem_rvalid_i) begin
                  merge   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (mem_rvalid_i) begin
               merge   = ~flush_i;
               state_d = S_IDLE;
            end else if (flush_i) begin
               state_d = S_DRAIN;
            end
         end
         default: begin
            if (mem_rvalid_i) state_d = S_IDLE;
         end
      endcase
   end

   // writeback register source: merged split result or aligned path
   always_comb begin
      wb_we_d    = 1'b0;
      wb_addr_d  = 5'd0;
      wb_data_d  = 32'd0;
      wb_split_d = 1'b0;
      if (merge) begin
         wb_we_d    = we_q;
         wb_addr_d  = rd_q;
         wb_data_d  = merge_data;
         wb_split_d = 1'b1;
      end else if (OREG) begin
         wb_we_d   = al_we;
         wb_addr_d = rd_i;
         wb_data_d = al_data;
      end
   end

   // state, first-beat capture and writeback registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         first_q    <= 32'd0;
         addr_q     <= 32'd0;
         off_q      <= 2'd0;
         op_q       <= NOP;
         rd_q       <= 5'd0;
         we_q       <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_addr_q  <= 5'd0;
         wb_data_q  <= 32'd0;
         wb_split_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wb_we_q    <= wb_we_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         wb_split_q <= wb_split_d;
         if (start) begin
            first_q <= mem_data_i;
            addr_q  <= {result_i[31:2] + 30'd1, 2'b00};
            off_q   <= off;
            op_q    <= instruction_operation_i;
            rd_q    <= rd_i;
            we_q    <= write_enable_i & (rd_i != 5'd0);
         end
      end
   end

   assign mem_req_o  = (state_q == S_REQ);
   assign mem_addr_o = addr_q;
   assign stall_o    = ~idle | start | hold;

   assign regbank_write_enable_o = (OREG | wb_split_q) ? wb_we_q   : al_we;
   assign regbank_addr_o         = (OREG | wb_split_q) ? wb_addr_q : rd_i;
   assign regbank_data_o         = (OREG | wb_split_q) ? wb_data_q : al_data;

`ifdef RETIRE_INSTRET_EN
   logic [63:0] instret_q;

   assign instret_inc_o = (accept & ~flush_i & ~mis) | merge;
   assign instret_o     = instret_q;

   // retired-instruction counter, wraps naturally at 2^64
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) instret_q <= 64'd0;
      else if (instret_inc_o) instret_q <= instret_q + 64'd1;
   end
`endif

endmodule

// File: tb/tb_retire_split.sv
// tb_retire_split: directed table vectors plus split-load sequences.
// u0 splits misaligned loads, u1 flags them.
module tb_retire_split;
   import retire_split_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        valid_i, flush_i, write_enable_i;
   logic [4:0]  rd_i;
   iType_e      op_i;
   logic [31:0] result_i, mem_data_i;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   logic        req0, stall0, mis0, we0;
   logic [31:0] maddr0, data0;
   logic [4:0]  addr0;
   logic        req1, stall1, mis1, we1;
   logic [31:0] maddr1, data1;
   logic [4:0]  addr1;
`ifdef RETIRE_INSTRET_EN
   logic [63:0] ir0, ir1, ir_snap;
   logic        inc0, inc1;
`endif

   int checks = 0;
   int errors = 0;

   retire_split #(.MISALIGNED(1), .OUT_REG(1)) u0 (
      .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .flush_i(flush_i),
      .write_enable_i(write_enable_i), .rd_i(rd_i),
      .instruction_operation_i(op_i), .result_i(result_i),
      .mem_data_i(mem_data_i), .mem_req_o(req0), .mem_addr_o(maddr0),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .stall_o(stall0), .misaligned_o(mis0),
`ifdef RETIRE_INSTRET_EN
      .instret_o(ir0), .instret_inc_o(inc0),
`endif
      .regbank_write_enable_o(we0), .regbank_addr_o(addr0),
      .regbank_data_o(data0)
   );

   retire_split #(.MISALIGNED(0), .OUT_REG(1)) u1 (
      .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .flush_i(flush_i),
      .write_enable_i(write_enable_i), .rd_i(rd_i),
      .instruction_operation_i(op_i), .result_i(result_i),
      .mem_data_i(mem_data_i), .mem_req_o(req1), .mem_addr_o(maddr1),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .stall_o(stall1), .misaligned_o(mis1),
`ifdef RETIRE_INSTRET_EN
      .instret_o(ir1), .instret_inc_o(inc1),
`endif
      .regbank_write_enable_o(we1), .regbank_addr_o(addr1),
      .regbank_data_o(data1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      iType_e      op;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] res;
      logic [31:0] md;
      logic        e_we;
      logic [31:0] e_data;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input iType_e op, input logic [31:0] res,
                        input logic [31:0] md, input logic [4:0] rd);
      valid_i        = 1'b1;
      op_i           = op;
      result_i       = res;
      mem_data_i     = md;
      rd_i           = rd;
      write_enable_i = 1'b1;
   endtask

   initial begin
      tbl[0] = '{LB,  1'b1, 5'd5,  32'h1003, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80};
      tbl[1] = '{LBU, 1'b1, 5'd5,  32'h1003, 32'h80FF_0000, 1'b1, 32'h0000_0080};
      tbl[2] = '{LH,  1'b1, 5'd2,  32'h1002, 32'h8001_0000, 1'b1, 32'hFFFF_8001};
      tbl[3] = '{LHU, 1'b1, 5'd3,  32'h1000, 32'h1234_F00D, 1'b1, 32'h0000_F00D};
      tbl[4] = '{LW,  1'b1, 5'd31, 32'h1000, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
      tbl[5] = '{ADD, 1'b1, 5'd0,  32'h0055, 32'h0,         1'b0, 32'h0000_0055};
      tbl[6] = '{ADD, 1'b1, 5'd7,  32'hCAFE, 32'h0,         1'b1, 32'h0000_CAFE};
      tbl[7] = '{ADD, 1'b0, 5'd9,  32'h0099, 32'h0,         1'b0, 32'h0000_0099};
      tbl[8] = '{LB,  1'b1, 5'd1,  32'h1001, 32'h0000_7F00, 1'b1, 32'h0000_007F};
      tbl[9] = '{LH,  1'b1, 5'd12, 32'h1001, 32'h00AB_CD00, 1'b1, 32'hFFFF_ABCD};

      reset_n = 1'b0;
      valid_i = 1'b0; flush_i = 1'b0; write_enable_i = 1'b0;
      rd_i = 5'd0; op_i = NOP; result_i = 32'd0; mem_data_i = 32'd0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;

      #1;
      chk("rst_we",    {63'd0, we0},    64'd0);
      chk("rst_data",  {32'd0, data0},  64'd0);
      chk("rst_addr",  {59'd0, addr0},  64'd0);
      chk("rst_stall", {63'd0, stall0}, 64'd0);
      chk("rst_req",   {63'd0, req0},   64'd0);
      chk("rst_maddr", {32'd0, maddr0}, 64'd0);
      chk("rst_mis1",  {63'd0, mis1},   64'd0);
`ifdef RETIRE_INSTRET_EN
      chk("rst_instret", ir0, 64'd0);
`endif
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // aligned / non-load vectors
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(tbl[i].op, tbl[i].res, tbl[i].md, tbl[i].rd);
         write_enable_i = tbl[i].we;
         #1;
         chk($sformatf("v%0d_stall", i), {63'd0, stall0}, 64'd0);
         chk($sformatf("v%0d_mis1", i),  {63'd0, mis1},   64'd0);
         @(posedge clk); #1;
         valid_i = 1'b0;
         chk($sformatf("v%0d_we", i),   {63'd0, we0},   {63'd0, tbl[i].e_we});
         chk($sformatf("v%0d_addr", i), {59'd0, addr0}, {59'd0, tbl[i].rd});
         chk($sformatf("v%0d_data", i), {32'd0, data0}, {32'd0, tbl[i].e_data});
      end

      // split LHU, grant after two waiting cycles, rvalid one later
      @(negedge clk);
      drive(LHU, 32'h2003, 32'hAB00_0000, 5'd3);
      #1;
      chk("A_stall_acc", {63'd0, stall0}, 64'd1);
      chk("A_mis1",      {63'd0, mis1},   64'd1);
      chk("A_stall1",    {63'd0, stall1}, 64'd0);
      @(posedge clk); #1;
      valid_i = 1'b0;
      chk("A_req",   {63'd0, req0},   64'd1);
      chk("A_maddr", {32'd0, maddr0}, 64'h2004);
      chk("A_we1",   {63'd0, we1},    64'd0);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         chk($sformatf("A_req_hold%0d", c),   {63'd0, req0},   64'd1);
         chk($sformatf("A_maddr_hold%0d", c), {32'd0, maddr0}, 64'h2004);
         chk($sformatf("A_stall_hold%0d", c), {63'd0, stall0}, 64'd1);
      end
      @(negedge clk); mem_gnt_i = 1'b1;
      @(posedge clk); #1; mem_gnt_i = 1'b0;
      chk("A_req_wait",   {63'd0, req0},   64'd0);
      chk("A_stall_wait", {63'd0, stall0}, 64'd1);
      @(negedge clk); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_00CD;
      #1;
      chk("A_stall_rv", {63'd0, stall0}, 64'd1);
      chk("A_we_rv",    {63'd0, we0},    64'd0);
      @(posedge clk); #1; mem_rvalid_i = 1'b0;
      chk("A_we",    {63'd0, we0},    64'd1);
      chk("A_data",  {32'd0, data0},  64'h0000_CDAB);
      chk("A_addr",  {59'd0, addr0},  64'd3);
      chk("A_stall", {63'd0, stall0}, 64'd0);

      // split LW with grant and rvalid together; u1 flags it
      @(negedge clk);
      drive(LW, 32'h3002, 32'h2211_0000, 5'd8);
      #1;
      chk("B_mis1",   {63'd0, mis1},   64'd1);
      chk("B_stall1", {63'd0, stall1}, 64'd0);
      @(posedge clk); #1;
      valid_i = 1'b0;
      chk("B_req0",  {63'd0, req0}, 64'd1);
      chk("B_req1",  {63'd0, req1}, 64'd0);
      chk("B_we1",   {63'd0, we1},  64'd0);
      @(negedge clk);
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_4433;
      @(posedge clk); #1;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      chk("B_we",    {63'd0, we0},    64'd1);
      chk("B_data",  {32'd0, data0},  64'h4433_2211);
      chk("B_addr",  {59'd0, addr0},  64'd8);
      chk("B_stall", {63'd0, stall0}, 64'd0);
      chk("B_req1b", {63'd0, req1},   64'd0);

      // split LH flushed in WAIT, data arrives three cycles later
      @(negedge clk);
      drive(LH, 32'h1003, 32'h1100_0000, 5'd4);
      @(posedge clk); #1; valid_i = 1'b0;
      @(negedge clk); mem_gnt_i = 1'b1;
      @(posedge clk); #1; mem_gnt_i = 1'b0;
      @(negedge clk); flush_i = 1'b1;
      @(posedge clk); #1; flush_i = 1'b0;
      chk("C_stall_fl", {63'd0, stall0}, 64'd1);
      chk("C_we_fl",    {63'd0, we0},    64'd0);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         chk($sformatf("C_stall_dr%0d", c), {63'd0, stall0}, 64'd1);
         chk($sformatf("C_we_dr%0d", c),    {63'd0, we0},    64'd0);
      end
      @(negedge clk); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0022;
      @(posedge clk); #1; mem_rvalid_i = 1'b0;
      chk("C_stall_end", {63'd0, stall0}, 64'd0);
      chk("C_we_end",    {63'd0, we0},    64'd0);
      @(negedge clk);
      drive(ADD, 32'h0000_0077, 32'h0, 5'd6);
      @(posedge clk); #1; valid_i = 1'b0;
      chk("C_next_we",   {63'd0, we0},   64'd1);
      chk("C_next_data", {32'd0, data0}, 64'h77);
      chk("C_next_addr", {59'd0, addr0}, 64'd6);

      // reset while a request is outstanding
      @(negedge clk);
      drive(LW, 32'h3002, 32'h2211_0000, 5'd8);
      @(posedge clk); #1; valid_i = 1'b0;
      chk("D_req_pre", {63'd0, req0}, 64'd1);
      @(negedge clk); reset_n = 1'b0;
      #1;
      chk("D_req",   {63'd0, req0},   64'd0);
      chk("D_stall", {63'd0, stall0}, 64'd0);
      chk("D_we",    {63'd0, we0},    64'd0);
      chk("D_data",  {32'd0, data0},  64'd0);
      chk("D_maddr", {32'd0, maddr0}, 64'd0);
      @(negedge clk); reset_n = 1'b1; mem_rvalid_i = 1'b1;
      @(posedge clk); #1; mem_rvalid_i = 1'b0;
      chk("D_late_we",    {63'd0, we0},    64'd0);
      chk("D_late_stall", {63'd0, stall0}, 64'd0);
      chk("D_late_req",   {63'd0, req0},   64'd0);

      // split LH at the top of the address space
      @(negedge clk);
      drive(LH, 32'hFFFF_FFFF, 32'h5A00_0000, 5'd10);
      @(posedge clk); #1; valid_i = 1'b0;
      chk("E_req",   {63'd0, req0},   64'd1);
      chk("E_maddr", {32'd0, maddr0}, 64'd0);
`ifdef RETIRE_INSTRET_EN
      ir_snap = ir0;
`endif
      @(negedge clk); mem_gnt_i = 1'b1;
      @(posedge clk); #1; mem_gnt_i = 1'b0;
      @(negedge clk); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_00A5;
      #1;
`ifdef RETIRE_INSTRET_EN
      chk("E_inc_pulse", {63'd0, inc0}, 64'd1);
      chk("E_ir_before", ir0, ir_snap);
`endif
      @(posedge clk); #1; mem_rvalid_i = 1'b0;
      chk("E_we",   {63'd0, we0},   64'd1);
      chk("E_data", {32'd0, data0}, 64'hFFFF_A55A);
      chk("E_addr", {59'd0, addr0}, 64'd10);
`ifdef RETIRE_INSTRET_EN
      chk("E_ir_after", ir0, ir_snap + 64'd1);
      chk("E_inc_off",  {63'd0, inc0}, 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/retire_split.md
Name: retire_split

Overview:
- Parametrised successor to the RS5 retire/writeback stage: load alignment and sign/zero extension, plus registered writeback, rd routing and flush.
- Adds hardware handling of misaligned loads that cross a 32-bit word boundary: the block issues a second memory read and merges the two beats.
- Sits between execute/memory and the register bank. It stalls upstream while a split load is in flight.

Parameters:
MISALIGNED, 1, 1 = split-and-merge misaligned loads; 0 = flag misaligned loads on misaligned_o and suppress the write
OUT_REG, 1, 1 = regbank_* outputs registered (1-cycle latency); 0 = regbank_* combinational from inputs (split result still registered)

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
valid_i  in  1  instruction present at retire; accepted only when stall_o=0
flush_i  in  1  kill current and in-flight instruction
write_enable_i  in  1  instruction writes rd
rd_i  in  5  destination register
instruction_operation_i  in  iType_e  operation (LB, LBU, LH, LHU, LW, others)
result_i  in  32  ALU result, or byte address for loads
mem_data_i  in  32  read data for the first (aligned) beat
mem_req_o  out  1  second-beat read request
mem_addr_o  out  32  second-beat word address: {result_i[31:2]+1, 2'b00}
mem_gnt_i  in  1  memory accepted mem_req_o
mem_rvalid_i  in  1  second-beat data valid
mem_rdata_i  in  32  second-beat data
stall_o  out  1  hold upstream
misaligned_o  out  1  one-cycle pulse, misaligned load with MISALIGNED=0
regbank_write_enable_o  out  1  register write strobe
regbank_addr_o  out  5  register index
regbank_data_o  out  32  write data

Behaviour:
- Reset: all outputs 0; FSM in IDLE; captured first beat, offset, op and rd cleared. Reset mid-split drops everything; a late mem_rvalid_i after reset is ignored in IDLE.
- Size: sz = 1 (LB/LBU), 2 (LH/LHU), 4 (LW). off = result_i[1:0]. Misaligned if off+sz>4.
- Aligned load: bytes off..off+sz-1 of mem_data_i. Sign-extend for LB/LH, zero-extend for LBU/LHU.
- Non-load: data = result_i.
- Write enable: write_enable_i & valid_i & (rd_i != 0) & ~flush_i.
- Aligned path latency: 1 cycle (OUT_REG=1) or 0 cycles (OUT_REG=0).
- FSM states:
  - IDLE: a valid misaligned load with MISALIGNED=1 and no flush captures {mem_data_i, off, op, rd, we} and computes mem_addr_o, then goes to REQ. stall_o=1 from that same cycle (combinational).
  - REQ: mem_req_o=1, mem_addr_o held stable until mem_gnt_i. On mem_gnt_i go to WAIT. If mem_gnt_i and mem_rvalid_i arrive in the same cycle, go straight to the merge.
  - WAIT: on mem_rvalid_i, merge {mem_rdata_i, captured}>>(off*8), take the low sz bytes, extend, register the write, then go to IDLE. stall_o drops in the cycle the write is presented.
  - DRAIN: entered on flush_i in WAIT, or on flush_i in REQ after the grant. Waits for mem_rvalid_i, discards the data, goes to IDLE. stall_o stays 1.
- flush_i in REQ before grant: deassert mem_req_o and go to IDLE next cycle. No write in any flush case.
- misaligned_o (MISALIGNED=0): pulses in the acceptance cycle; write suppressed; no stall.
- valid_i while stall_o=1 is ignored; upstream holds the instruction.
- Address wrap: result_i[31:2]=all ones gives mem_addr_o = 0x0000_0000.

Optional Feature:
RETIRE_INSTRET_EN:
- Defined: adds ports instret_o (out, 64) and instret_inc_o (out, 1).
  - instret_inc_o pulses once per retired instruction: non-flushed and not flagged misaligned. For a split load the pulse comes at merge completion.
  - instret_o resets to 0 and wraps at 2^64.
- Not defined: these ports and the counter logic are absent.

Test Plan:
- LB, result_i=0x1003, mem_data_i=0x80FF_0000 -> next cycle regbank_data_o=0xFFFF_FF80, write enable 1, no stall.
- LHU at 0x2003, mem_data_i=0xAB00_0000, mem_rdata_i=0x0000_00CD, gnt after 2 cycles, rvalid 1 cycle later -> mem_addr_o=0x2004; data=0x0000_CDAB; stall_o high from accept until write.
- LW at 0x3002, first=0x2211_0000, second=0x0000_4433 -> data=0x4433_2211. Repeat with MISALIGNED=0 -> misaligned_o pulse, no write, mem_req_o never set.
- Split LH, flush_i in WAIT, rvalid 3 cycles later -> no write; stall_o held until rvalid, then IDLE; next aligned instruction retires normally.
- ADD with rd_i=0, write_enable_i=1 -> regbank_write_enable_o=0. Assert reset_n=0 during REQ -> mem_req_o and stall_o drop immediately; all outputs 0.
- LH at 0xFFFF_FFFF with RETIRE_INSTRET_EN -> mem_addr_o=0x0; instret_o increments by exactly 1 at merge.
